// File: rtl/mvau_inp_buf_ctrl.sv
// Input-buffer controller for the MVAU: writes each activation vector once while passing it through,
// then replays it NF-1 times. Optional stall counter enabled by defining MVAU_INP_CTRL_STALL_CNT_EN.
module mvau_inp_buf_ctrl #(
    parameter int MatrixW  = 20,
    parameter int SIMD     = 2,
    parameter int MatrixH  = 20,
    parameter int PE       = 2,
    parameter int BUF_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                buf_wr_en,
    output logic                buf_rd_en,
    output logic [BUF_ADDR-1:0] buf_addr,
    output logic                sf_last,
    output logic                nf_last
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int SF   = MatrixW / SIMD;
    localparam int NF   = MatrixH / PE;
    localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);

    if (MatrixW % SIMD != 0) begin : g_chk_simd
        $error("MatrixW must be a multiple of SIMD");
    end
    if (MatrixH % PE != 0) begin : g_chk_pe
        $error("MatrixH must be a multiple of PE");
    end
    if (BUF_ADDR < SF_W) begin : g_chk_addr
        $error("BUF_ADDR too narrow to address SF words");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        REUSE = 2'd2
    } state_t;

    state_t          state;
    logic [SF_W-1:0] sf_cnt;
    logic [NF_W-1:0] nf_cnt;
    logic            mv;
    logic            xfer;

    // Outputs are combinational so a stored word reaches compute in the same cycle it is addressed.
    always_comb begin
        s_ready   = 1'b0;
        mv        = 1'b0;
        buf_wr_en = 1'b0;
        buf_rd_en = 1'b0;
        buf_addr  = '0;
        xfer      = 1'b0;
        case (state)
            FILL: begin
                s_ready   = m_ready;
                mv        = s_valid;
                buf_wr_en = s_valid & m_ready;
                buf_addr  = BUF_ADDR'(sf_cnt);
                xfer      = s_valid & m_ready;
            end
            REUSE: begin
                mv        = 1'b1;
                buf_rd_en = 1'b1;
                buf_addr  = BUF_ADDR'(sf_cnt);
                xfer      = m_ready;
            end
            default: ;
        endcase
        m_valid = mv;
        sf_last = mv & (sf_cnt == SF_MAX);
        nf_last = mv & (nf_cnt == NF_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sf_cnt <= '0;
            nf_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (xfer) begin
                        if (sf_cnt == SF_MAX) begin
                            sf_cnt <= '0;
                            if (NF == 1) begin
                                nf_cnt <= '0;
                            end else begin
                                nf_cnt <= NF_W'(1);
                                state  <= REUSE;
                            end
                        end else begin
                            sf_cnt <= sf_cnt + SF_W'(1);
                        end
                    end
                end
                REUSE: begin
                    if (xfer) begin
                        if (sf_cnt == SF_MAX) begin
                            sf_cnt <= '0;
                            if (nf_cnt == NF_MAX) begin
                                nf_cnt <= '0;
                                state  <= FILL;
                            end else begin
                                nf_cnt <= nf_cnt + NF_W'(1);
                            end
                        end else begin
                            sf_cnt <= sf_cnt + SF_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MVAU_INP_CTRL_STALL_CNT_EN
    // Saturating count of cycles where compute back-pressures a presented word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (mv && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Scoreboard bench for mvau_inp_buf_ctrl: NF=3 instance (SF=4) and an NF=1 instance.
module tb_mvau_inp_buf_ctrl;

    logic       clk;
    logic       rst_n, rst1_n;
    logic       s_valid, m_ready, s_valid1, m_ready1;
    logic       s_ready, m_valid, buf_wr_en, buf_rd_en, sf_last, nf_last;
    logic       s_ready1, m_valid1, buf_wr_en1, buf_rd_en1, sf_last1, nf_last1;
    logic [3:0] buf_addr, buf_addr1;
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt1, stall_base;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [9:0] e0;
        logic [9:0] e1;
    } exp_t;
    exp_t q[$];

    mvau_inp_buf_ctrl #(.MatrixW(8), .SIMD(2), .MatrixH(6), .PE(2), .BUF_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .buf_wr_en(buf_wr_en),
        .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .sf_last(sf_last), .nf_last(nf_last)
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mvau_inp_buf_ctrl #(.MatrixW(8), .SIMD(2), .MatrixH(2), .PE(2), .BUF_ADDR(4)) dut1 (
        .clk(clk), .rst_n(rst1_n), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_valid(m_valid1), .m_ready(m_ready1), .buf_wr_en(buf_wr_en1),
        .buf_rd_en(buf_rd_en1), .buf_addr(buf_addr1), .sf_last(sf_last1), .nf_last(nf_last1)
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] o(input logic sr, input logic mv, input logic wr,
                                     input logic rd, input int addr, input logic sl,
                                     input logic nl);
        return {sr, mv, wr, rd, 4'(addr), sl, nl};
    endfunction

    function automatic logic [9:0] fillw(input int a);
        return o(1'b1, 1'b1, 1'b1, 1'b0, a, a == 3, 1'b0);
    endfunction

    function automatic logic [9:0] reusew(input int a, input int n);
        return o(1'b0, 1'b1, 1'b0, 1'b1, a, a == 3, n == 2);
    endfunction

    // Monitor: compares the presented outputs of both instances against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t r;
            logic [9:0] g0, g1;
            r  = q.pop_front();
            g0 = {s_ready, m_valid, buf_wr_en, buf_rd_en, buf_addr, sf_last, nf_last};
            g1 = {s_ready1, m_valid1, buf_wr_en1, buf_rd_en1, buf_addr1, sf_last1, nf_last1};
            checks++;
            if (g0 !== r.e0 || g1 !== r.e1) begin
                errors++;
                $display("FAIL %s got %b/%b expected %b/%b (sr mv wr rd addr sl nl)",
                         r.tag, g0, g1, r.e0, r.e1);
            end
        end
    end

    task automatic step(input string tag, input logic [9:0] e0, input logic [9:0] e1);
        exp_t r;
        r.tag = tag;
        r.e0  = e0;
        r.e1  = e1;
        q.push_back(r);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic vector(input string tag);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int a = 0; a < 4; a++) step(tag, fillw(a), 10'd0);
        for (int n = 1; n < 3; n++)
            for (int a = 0; a < 4; a++) step(tag, reusew(a, n), 10'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        s_valid = 1'b1; m_ready = 1'b1;
        s_valid1 = 1'b0; m_ready1 = 1'b0;
        step("reset_hold", 10'd0, 10'd0);
        step("reset_hold", 10'd0, 10'd0);
        rst_n = 1'b1;
        step("idle", 10'd0, 10'd0);

        vector("stream");
        s_valid = 1'b0;
        step("refill", o(1, 0, 0, 0, 0, 0, 0), 10'd0);

        s_valid = 1'b1;
        for (int a = 0; a < 4; a++) step("bp_fill", fillw(a), 10'd0);
        step("bp_reuse", reusew(0, 1), 10'd0);
        step("bp_reuse", reusew(1, 1), 10'd0);
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
        stall_base = stall_cnt;
`endif
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("bp_hold", reusew(2, 1), 10'd0);
`ifdef MVAU_INP_CTRL_STALL_CNT_EN
        checks++;
        if (stall_cnt !== stall_base + 32'd3) begin
            errors++;
            $display("FAIL stall_cnt got %0d expected %0d", stall_cnt, stall_base + 32'd3);
        end
`endif
        m_ready = 1'b1;
        step("bp_resume", reusew(2, 1), 10'd0);
        step("bp_resume", reusew(3, 1), 10'd0);
        for (int a = 0; a < 4; a++) step("bp_last", reusew(a, 2), 10'd0);

        step("bubble_fill", fillw(0), 10'd0);
        s_valid = 1'b0;
        step("bubble", o(1, 0, 0, 0, 1, 0, 0), 10'd0);
        step("bubble", o(1, 0, 0, 0, 1, 0, 0), 10'd0);
        s_valid = 1'b1;
        for (int a = 1; a < 4; a++) step("bubble_resume", fillw(a), 10'd0);
        for (int a = 0; a < 3; a++) step("pre_rst", reusew(a, 1), 10'd0);
        m_ready = 1'b0;
        step("pre_rst_hold", reusew(3, 1), 10'd0);
        rst_n = 1'b0;
        step("rst_mid", 10'd0, 10'd0);
        step("rst_mid", 10'd0, 10'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        step("idle_after_rst", 10'd0, 10'd0);
        vector("after_rst");

        s_valid = 1'b0; m_ready = 1'b0;
        rst1_n = 1'b1;
        s_valid1 = 1'b1; m_ready1 = 1'b1;
        step("nf1_idle", 10'd0, 10'd0);
        for (int i = 0; i < 12; i++)
            step("nf1_stream", 10'd0, o(1, 1, 1, 0, i % 4, (i % 4) == 3, 1'b1));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
